// File: rtl/sram_march_sequencer.sv
// March C- BIST sequencer for the OpenRAM test macros: issues per-op SRAM packets and checks read data.
// Optional build macro DUAL_PORT_CHECK_EN: reads also drive port 1 and compare rd_data1.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | op fields valid for one cycle (op_valid=1)
// WAIT    | read in flight, READ_LAT cycles
// CHECK   | compare returned read data
// DONE    | one-cycle done pulse, pass valid
module sram_march_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int READ_LAT   = 2
) (
    input  logic                  la_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic [ADDR_WIDTH-1:0] depth_m1,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  op_valid,
    output logic [SEL_WIDTH-1:0]  op_sel,
    output logic [ADDR_WIDTH-1:0] op_addr0,
    output logic [DATA_WIDTH-1:0] op_din0,
    output logic                  op_csb0,
    output logic                  op_web0,
    output logic [3:0]            op_wmask0,
    output logic [ADDR_WIDTH-1:0] op_addr1,
    output logic                  op_csb1,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int TW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [TW-1:0] WAIT_LOAD = TW'(READ_LAT - 1);

    logic [2:0]            state;
    logic [2:0]            elem;
    logic                  step;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] depth_q;
    logic [TW-1:0]         timer;

    // Element e op s: M0 has only w0, M5 only r0, M1..M4 are (read, write) pairs.
    function automatic logic op_is_read(input logic [2:0] e, input logic s);
        return (e != 3'd0) && !s;
    endfunction

    function automatic logic op_bit(input logic [2:0] e, input logic s);
        case (e)
            3'd1, 3'd3: return s;
            3'd2, 3'd4: return !s;
            default:    return 1'b0;
        endcase
    endfunction

    logic                  cur_read, cur_bit, is_down, two_op, last_addr, last_op;
    logic [2:0]            nxt_elem;
    logic                  nxt_step;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    assign cur_read  = op_is_read(elem, step);
    assign cur_bit   = op_bit(elem, step);
    assign is_down   = (elem == 3'd3) || (elem == 3'd4);
    assign two_op    = (elem != 3'd0) && (elem != 3'd5);
    assign last_addr = is_down ? (addr == '0) : (addr == depth_q);
    assign last_op   = (elem == 3'd5) && last_addr;

    always_comb begin
        nxt_elem = elem;
        nxt_step = 1'b0;
        nxt_addr = addr;
        if (two_op && !step) begin
            nxt_step = 1'b1;
        end else if (!last_addr) begin
            nxt_addr = is_down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end else begin
            nxt_elem = elem + 3'd1;
            nxt_addr = ((elem == 3'd2) || (elem == 3'd3)) ? depth_q : '0;
        end
    end

    logic                  start_acc, adv, load, ld_read, ld_bit, ld_step;
    logic [2:0]            ld_elem;
    logic [ADDR_WIDTH-1:0] ld_addr;

    assign start_acc = (state == S_IDLE) && start;
    assign adv       = ((state == S_ISSUE) && !cur_read) || ((state == S_CHECK) && !last_op);
    assign load      = start_acc || adv;
    assign ld_elem   = start_acc ? 3'd0 : nxt_elem;
    assign ld_step   = start_acc ? 1'b0 : nxt_step;
    assign ld_addr   = start_acc ? '0 : nxt_addr;
    assign ld_read   = op_is_read(ld_elem, ld_step);
    assign ld_bit    = op_bit(ld_elem, ld_step);

    logic                  mis0, mis1;
    logic [1:0]            err_inc;
    logic [16:0]           err_sum;
    logic [15:0]           err_nxt;

    assign mis0 = rd_data0 != {DATA_WIDTH{cur_bit}};
`ifdef DUAL_PORT_CHECK_EN
    assign mis1 = rd_data1 != {DATA_WIDTH{cur_bit}};
`else
    logic unused_rd1;
    assign mis1       = 1'b0;
    assign unused_rd1 = ^rd_data1;
`endif
    assign err_inc = {1'b0, mis0} + {1'b0, mis1};
    assign err_sum = {1'b0, err_count} + {15'd0, err_inc};
    assign err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    assign busy     = (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    assign done     = (state == S_DONE);
    assign op_valid = (state == S_ISSUE);
    assign op_csb0  = !(state == S_ISSUE);

    always_ff @(posedge la_clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            elem    <= '0;
            step    <= 1'b0;
            addr    <= '0;
            depth_q <= '0;
            timer   <= '0;
        end else begin
            if (start_acc) depth_q <= depth_m1;
            if (load) begin
                elem <= ld_elem;
                step <= ld_step;
                addr <= ld_addr;
            end
            case (state)
                S_IDLE:  if (start) state <= S_ISSUE;
                S_ISSUE: if (cur_read) begin
                    timer <= WAIT_LOAD;
                    state <= S_WAIT;
                end
                S_WAIT:  if (timer == '0) state <= S_CHECK;
                         else timer <= timer - TW'(1);
                S_CHECK: state <= last_op ? S_DONE : S_ISSUE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge la_clk or posedge reset) begin
        if (reset) begin
            op_sel    <= '0;
            op_addr0  <= '0;
            op_din0   <= '0;
            op_web0   <= 1'b1;
            op_wmask0 <= 4'h0;
        end else if (load) begin
            if (start_acc) op_sel <= sel_in;
            op_addr0  <= ld_addr;
            op_din0   <= {DATA_WIDTH{ld_bit}};
            op_web0   <= ld_read;
            op_wmask0 <= ld_read ? 4'h0 : 4'hF;
        end
    end

    always_ff @(posedge la_clk or posedge reset) begin
        if (reset) begin
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (start_acc) begin
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (state == S_CHECK) begin
            err_count <= err_nxt;
            if (err_count == '0 && mis0) begin
                fail_addr <= addr;
                fail_data <= rd_data0;
            end else if (err_count == '0 && mis1) begin
                fail_addr <= addr;
                fail_data <= rd_data1;
            end
            if (last_op) pass <= (err_nxt == '0);
        end
    end

`ifdef DUAL_PORT_CHECK_EN
    assign op_csb1 = !((state == S_ISSUE) && op_web0);
    always_ff @(posedge la_clk or posedge reset) begin
        if (reset) op_addr1 <= '0;
        else if (load && ld_read) op_addr1 <= ld_addr;
    end
`else
    assign op_csb1  = 1'b1;
    assign op_addr1 = '0;
`endif
endmodule

// File: tb/tb_sram_march_sequencer.sv
// Scoreboard bench for sram_march_sequencer: behavioural SRAM with stuck-at faults plus a loop-based March C- model.
module tb_sram_march_sequencer;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int RL = 2;

    logic          la_clk = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] sel_in;
    logic [AW-1:0] depth_m1;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          op_valid;
    logic [SW-1:0] op_sel;
    logic [AW-1:0] op_addr0, op_addr1;
    logic [DW-1:0] op_din0;
    logic          op_csb0, op_web0, op_csb1;
    logic [3:0]    op_wmask0;
    logic [DW-1:0] rd_data0, rd_data1;

    sram_march_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .READ_LAT(RL)) dut (
        .la_clk(la_clk), .reset(reset), .start(start), .sel_in(sel_in), .depth_m1(depth_m1),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .fail_data(fail_data), .op_valid(op_valid), .op_sel(op_sel),
        .op_addr0(op_addr0), .op_din0(op_din0), .op_csb0(op_csb0), .op_web0(op_web0),
        .op_wmask0(op_wmask0), .op_addr1(op_addr1), .op_csb1(op_csb1),
        .rd_data0(rd_data0), .rd_data1(rd_data1)
    );

    always #5 la_clk = ~la_clk;

`ifdef DUAL_PORT_CHECK_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    typedef struct {bit wr; int addr; logic [DW-1:0] data; logic [SW-1:0] sel;} op_t;
    typedef struct {bit pass; int err; int faddr; logic [DW-1:0] fdata;} res_t;

    op_t  exp_q[$];
    res_t res_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_ops = 0;
    int   n_done = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Behavioural SRAM: stuck-at masks applied on write, READ_LAT-cycle read pipe, output held.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] sa0 [64];
    logic [DW-1:0] sa1 [64];
    logic [DW-1:0] pipe_d [RL];
    logic          pipe_v [RL];
    logic [DW-1:0] dout_hold;

    always @(posedge la_clk) begin
        if (op_valid && !op_csb0 && !op_web0)
            mem[op_addr0[5:0]] <= (op_din0 & ~sa0[op_addr0[5:0]]) | sa1[op_addr0[5:0]];
        pipe_v[0] <= op_valid && !op_csb0 && op_web0;
        pipe_d[0] <= mem[op_addr0[5:0]];
        for (int k = 1; k < RL; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_d[k] <= pipe_d[k-1];
        end
        dout_hold <= rd_data0;
    end
    assign rd_data0 = pipe_v[RL-1] ? pipe_d[RL-1] : dout_hold;

`ifdef DUAL_PORT_CHECK_EN
    assign rd_data1 = '0;
`else
    logic [DW-1:0] junk;
    always @(posedge la_clk) junk <= $urandom;
    assign rd_data1 = junk;
`endif

    op_t  mon_e;
    res_t mon_r;

    always @(negedge la_clk) begin
        if (!reset) begin
            if (op_valid) begin
                n_ops++;
                if (exp_q.size() == 0) fail_now("unexpected_op");
                else begin
                    mon_e = exp_q.pop_front();
                    chk("op_addr0", op_addr0, mon_e.addr);
                    chk("op_web0", op_web0, !mon_e.wr);
                    chk("op_wmask0", op_wmask0, mon_e.wr ? 4'hF : 4'h0);
                    if (mon_e.wr) chk("op_din0", op_din0, mon_e.data);
                    chk("op_sel", op_sel, mon_e.sel);
                    chk("op_csb0", op_csb0, 1'b0);
                    if (DUAL && !mon_e.wr) begin
                        chk("op_csb1", op_csb1, 1'b0);
                        chk("op_addr1", op_addr1, mon_e.addr);
                    end else if (!DUAL) begin
                        chk("op_csb1", op_csb1, 1'b1);
                        chk("op_addr1", op_addr1, 0);
                    end
                end
            end else if (busy) begin
                chk("op_csb0_idle", op_csb0, 1'b1);
            end
            if (done) begin
                n_done++;
                chk("busy_at_done", busy, 1'b0);
                if (res_q.size() == 0) fail_now("unexpected_done");
                else begin
                    mon_r = res_q.pop_front();
                    chk("pass", pass, mon_r.pass);
                    chk("err_count", err_count, mon_r.err);
                    chk("fail_addr", fail_addr, mon_r.faddr);
                    chk("fail_data", fail_data, mon_r.fdata);
                end
            end
        end
    end

    // March C- as a list: element op counts, read/write and data bit per op.
    task automatic build_model(input int depth, input logic [SW-1:0] sel, output bit exp_pass);
        int            nops [6] = '{1, 2, 2, 2, 2, 1};
        bit            btab [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
        logic [DW-1:0] rm [64];
        int            err = 0;
        int            fa = 0;
        logic [DW-1:0] fd = '0;
        for (int e = 0; e < 6; e++) begin
            for (int ai = 0; ai <= depth; ai++) begin
                int a = (e == 3 || e == 4) ? depth - ai : ai;
                for (int s = 0; s < nops[e]; s++) begin
                    bit            rd = (e != 0) && (s == 0);
                    logic [DW-1:0] d = btab[e][s] ? '1 : '0;
                    op_t           o;
                    o.wr = !rd; o.addr = a; o.data = d; o.sel = sel;
                    exp_q.push_back(o);
                    if (!rd) rm[a] = (d & ~sa0[a]) | sa1[a];
                    else begin
                        if (rm[a] != d) begin
                            if (err == 0) begin fa = a; fd = rm[a]; end
                            err++;
                        end
                        if (DUAL && d != '0) begin
                            if (err == 0) begin fa = a; fd = '0; end
                            err++;
                        end
                    end
                end
            end
        end
        begin
            res_t r;
            r.pass = (err == 0); r.err = err; r.faddr = fa; r.fdata = fd;
            res_q.push_back(r);
            exp_pass = r.pass;
        end
    endtask

    task automatic set_fault(input int faddr, input int fbit, input bit fsa1);
        for (int i = 0; i < 64; i++) begin sa0[i] = '0; sa1[i] = '0; end
        if (faddr >= 0) begin
            if (fsa1) sa1[faddr][fbit] = 1'b1;
            else      sa0[faddr][fbit] = 1'b1;
        end
    endtask

    task automatic pulse_start(input int depth, input logic [SW-1:0] sel);
        @(negedge la_clk);
        sel_in = sel; depth_m1 = AW'(depth); start = 1'b1;
        @(negedge la_clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic run_test(input int depth, input logic [SW-1:0] sel, input int faddr,
                            input int fbit, input bit fsa1, input bit restart);
        bit exp_pass;
        int ops0, done0, cyc;
        set_fault(faddr, fbit, fsa1);
        build_model(depth, sel, exp_pass);
        ops0 = n_ops; done0 = n_done;
        pulse_start(depth, sel);
        if (restart) begin
            repeat (6) @(negedge la_clk);
            sel_in = ~sel; depth_m1 = AW'(depth + 2); start = 1'b1;
            @(negedge la_clk);
            start = 1'b0;
        end
        cyc = 0;
        while (n_done == done0 && cyc < 5000) begin @(negedge la_clk); cyc++; end
        if (n_done == done0) begin
            fail_now("done_timeout");
            exp_q.delete(); res_q.delete();
        end
        @(negedge la_clk);
        chk("op_count", n_ops - ops0, 10 * (depth + 1));
        chk("done_count", n_done - done0, 1);
        chk("pass_held", pass, exp_pass);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic reset_test();
        bit exp_pass;
        int ops0, done0, cyc;
        set_fault(0, 0, 1'b1);
        build_model(3, 4'h2, exp_pass);
        ops0 = n_ops; done0 = n_done;
        pulse_start(3, 4'h2);
        cyc = 0;
        while (n_ops - ops0 < 14 && cyc < 2000) begin @(negedge la_clk); cyc++; end
        if (n_ops - ops0 < 14) fail_now("reset_wait_timeout");
        chk("err_before_reset", err_count, DUAL ? 2 : 1);
        @(posedge la_clk);
        #2 reset = 1'b1;
        exp_q.delete(); res_q.delete();
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_csb0", op_csb0, 1'b1);
        chk("rst_err", err_count, 0);
        @(negedge la_clk);
        chk("rst_busy_next", busy, 1'b0);
        chk("rst_csb0_next", op_csb0, 1'b1);
        reset = 1'b0;
        repeat (30) @(negedge la_clk);
        chk("no_done_after_reset", n_done, done0);
        chk("idle_after_reset", busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sel_in = '0; depth_m1 = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom; sa0[i] = '0; sa1[i] = '0;
        end
        for (int k = 0; k < RL; k++) begin pipe_v[k] = 1'b0; pipe_d[k] = '0; end
        dout_hold = '0;
        repeat (3) @(negedge la_clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_pass", pass, 1'b0);
        chk("reset_err", err_count, 0);
        chk("reset_fail_addr", fail_addr, 0);
        chk("reset_fail_data", fail_data, 0);
        chk("reset_op_valid", op_valid, 1'b0);
        chk("reset_csb0", op_csb0, 1'b1);
        chk("reset_csb1", op_csb1, 1'b1);
        chk("reset_web0", op_web0, 1'b1);
        chk("reset_wmask0", op_wmask0, 0);
        chk("reset_addr0", op_addr0, 0);
        chk("reset_addr1", op_addr1, 0);
        chk("reset_din0", op_din0, 0);
        chk("reset_sel", op_sel, 0);
        reset = 1'b0;
        repeat (2) @(negedge la_clk);

        run_test(3, 4'h1, -1, 0, 1'b0, 1'b0);
        run_test(3, 4'h5, 2, 5, 1'b0, 1'b0);
        if (!DUAL) begin
            chk("sa0_fail_data", fail_data, 32'hFFFFFFDF);
            chk("sa0_err", err_count, 2);
        end
        run_test(0, 4'hA, -1, 0, 1'b0, 1'b0);
        run_test(3, 4'h1, -1, 0, 1'b0, 1'b1);
        reset_test();
        for (int t = 0; t < 8; t++) begin
            int d = $urandom_range(0, 9);
            bit f = $urandom_range(0, 1) == 1;
            run_test(d, SW'($urandom), f ? $urandom_range(0, d) : -1,
                     $urandom_range(0, DW - 1), $urandom_range(0, 1) == 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
